// File: rtl/pipe_dbg_pkg.sv
// Shared encodings for the pipeline run/halt/step controller:
// debug command opcodes, controller state and default counter width.
package pipe_dbg_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_RUN    = 3'd1,
        OP_HALT   = 3'd2,
        OP_STEP   = 3'd3,
        OP_SETBP  = 3'd4,
        OP_CLRBP  = 3'd5,
        OP_CLRCNT = 3'd6,
        OP_RSVD   = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } run_state_e;

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Debug command port: valid/ready handshake carrying an opcode and a 32-bit argument.
interface pipe_run_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up while enabled, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step controller for the 5-stage pipeline. Drives the global
// pipeline enable, takes debug commands, halts on a PC breakpoint and keeps
// saturating performance counters.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_RUN    | pipeline free-running, cpu_en = 1
//   ST_HALTED | pipeline frozen, cpu_en = 0, waiting for RUN/STEP
//   ST_STEP   | running a bounded number of enabled cycles, then halts
module pipe_run_ctrl
    import pipe_dbg_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b1,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    pipe_run_ctrl_if.slave   cmd,
    input  logic [31:0]      pc_if,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             retire_in,
    output logic             cpu_en,
    output logic             halted,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam run_state_e RST_STATE = RUN_ON_RESET ? ST_RUN : ST_HALTED;

    run_state_e       state;
    run_state_e       st_nxt;
    logic [CNT_W-1:0] step_rem;
    logic [CNT_W-1:0] step_arg;
    logic [CNT_W-1:0] step_load;
    logic             load_step;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic             skip_bp;
    cmd_op_e          op;
    logic             acc;
    logic             acc_halt;
    logic             bp_match;
    logic             step_last;
    logic             cnt_clr;

    assign op = cmd_op_e'(cmd.cmd_op);

    // HALT must always get through, even while a step sequence owns the port.
    assign cmd.cmd_ready = (state != ST_STEP) || (op == OP_HALT);

    assign acc      = cmd.cmd_valid && cmd.cmd_ready;
    assign acc_halt = acc && (op == OP_HALT);
    assign cnt_clr  = acc && (op == OP_CLRCNT);

    // A step count of zero is treated as a single step.
    assign step_arg  = CNT_W'(cmd.cmd_arg);
    assign step_load = (step_arg == '0) ? CNT_W'(1) : step_arg;

    // skip_bp masks the first enabled cycle after leaving HALTED so the core
    // can resume from the very PC it stopped on.
    assign bp_match  = bp_en && !skip_bp && (state != ST_HALTED) && (pc_if == bp_addr);
    assign step_last = (state == ST_STEP) && (step_rem == CNT_W'(1));

    // Next-state decode; halting sources are merged so simultaneous events all land in HALTED.
    always_comb begin
        st_nxt    = state;
        load_step = 1'b0;
        case (state)
            ST_RUN: begin
                if (bp_match || acc_halt) begin
                    st_nxt = ST_HALTED;
                end else if (acc && (op == OP_STEP)) begin
                    st_nxt    = ST_STEP;
                    load_step = 1'b1;
                end
            end
            ST_STEP: begin
                if (step_last || bp_match || acc_halt) begin
                    st_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (acc && (op == OP_RUN)) begin
                    st_nxt = ST_RUN;
                end else if (acc && (op == OP_STEP)) begin
                    st_nxt    = ST_STEP;
                    load_step = 1'b1;
                end
            end
            default: begin
                st_nxt = RST_STATE;
            end
        endcase
    end

    // State register with registered enable/status outputs and event pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RST_STATE;
            cpu_en    <= RUN_ON_RESET;
            halted    <= !RUN_ON_RESET;
            step_rem  <= '0;
            skip_bp   <= 1'b0;
            step_done <= 1'b0;
            bp_hit    <= 1'b0;
        end else begin
            state     <= st_nxt;
            cpu_en    <= (st_nxt != ST_HALTED);
            halted    <= (st_nxt == ST_HALTED);
            skip_bp   <= (state == ST_HALTED) && (st_nxt != ST_HALTED);
            step_done <= step_last;
            bp_hit    <= bp_match;
            if (load_step) begin
                step_rem <= step_load;
            end else if (state == ST_STEP) begin
                step_rem <= step_rem - CNT_W'(1);
            end
        end
    end

    // Breakpoint address/enable, written only by SETBP and CLRBP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_en   <= 1'b0;
            bp_addr <= '0;
        end else if (acc && (op == OP_SETBP)) begin
            bp_en   <= 1'b1;
            bp_addr <= cmd.cmd_arg;
        end else if (acc && (op == OP_CLRBP)) begin
            bp_en <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (cpu_en),
        .clr  (cnt_clr),
        .cnt  (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (cpu_en && stall_in),
        .clr  (cnt_clr),
        .cnt  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (cpu_en && flush_in),
        .clr  (cnt_clr),
        .cnt  (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (cpu_en && retire_in),
        .clr  (cnt_clr),
        .cnt  (retire_cnt)
    );

endmodule
